// File: rtl/key_tracker.sv
// PS/2 Set-2 key-state tracker: parses E0/F0 prefixes, matches resolved codes against a
// run-time programmable key table and drives held state, edge pulses and hold counters.
module key_tracker #(
    parameter int NUM_KEYS = 14,
    parameter int HOLD_W   = 8,
    parameter logic [NUM_KEYS*9-1:0] DEFAULT_MAP = {
        9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h02C, 9'h035, 9'h03C,
        9'h175, 9'h172, 9'h16B, 9'h174, 9'h041, 9'h049, 9'h04A
    },
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid,
    input  logic                       frame_tick,
    input  logic                       clear,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic [8:0]                 cfg_code,
    output logic [NUM_KEYS-1:0]        keys,
    output logic [NUM_KEYS-1:0]        key_pressed,
    output logic [NUM_KEYS-1:0]        key_released,
    output logic [NUM_KEYS*HOLD_W-1:0] hold_cnt,
    output logic                       proto_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0]        PFX_EXT  = 8'hE0;
    localparam logic [7:0]        PFX_BRK  = 8'hF0;
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

    logic [1:0]                 state_q, state_d;
    logic [NUM_KEYS*9-1:0]      table_q, table_d;
    logic [NUM_KEYS-1:0]        keys_q, keys_d;
    logic [NUM_KEYS-1:0]        pressed_q, pressed_d;
    logic [NUM_KEYS-1:0]        released_q, released_d;
    logic [NUM_KEYS*HOLD_W-1:0] hold_q, hold_d;
    logic                       err_q, err_d;

    logic       res_vld;
    logic       res_brk;
    logic [8:0] res_code;

    // Prefix parser: yields at most one resolved {ext, code} make/break per byte.
    always_comb begin
        state_d  = state_q;
        err_d    = 1'b0;
        res_vld  = 1'b0;
        res_brk  = 1'b0;
        res_code = 9'h000;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_in == PFX_EXT) begin
                        state_d = ST_EXT;
                    end else if (byte_in == PFX_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        res_vld  = 1'b1;
                        res_code = {1'b0, byte_in};
                    end
                end
                ST_EXT: begin
                    if (byte_in == PFX_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (byte_in == PFX_EXT) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        res_vld  = 1'b1;
                        res_code = {1'b1, byte_in};
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (byte_in == PFX_EXT || byte_in == PFX_BRK) begin
                        err_d = 1'b1;
                    end else begin
                        res_vld  = 1'b1;
                        res_brk  = 1'b1;
                        res_code = {(state_q == ST_EXT_BRK), byte_in};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (clear) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
        end
    end

    // Per-key update; a table write to an entry overrides any match on that same entry.
    always_comb begin
        table_d    = table_q;
        keys_d     = keys_q;
        pressed_d  = '0;
        released_d = '0;
        hold_d     = hold_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (frame_tick && keys_q[i] && (hold_q[i*HOLD_W +: HOLD_W] != HOLD_MAX)) begin
                hold_d[i*HOLD_W +: HOLD_W] = hold_q[i*HOLD_W +: HOLD_W] + HOLD_W'(1);
            end
            if (cfg_we && (int'(cfg_idx) == i)) begin
                table_d[i*9 +: 9]          = cfg_code;
                keys_d[i]                  = 1'b0;
                hold_d[i*HOLD_W +: HOLD_W] = '0;
            end else if (res_vld && (table_q[i*9 +: 9] != 9'h000) &&
                         (table_q[i*9 +: 9] == res_code)) begin
                if (!res_brk && !keys_q[i]) begin
                    keys_d[i]                  = 1'b1;
                    pressed_d[i]               = 1'b1;
                    hold_d[i*HOLD_W +: HOLD_W] = '0;
                end else if (res_brk && keys_q[i]) begin
                    keys_d[i]                  = 1'b0;
                    released_d[i]              = 1'b1;
                    hold_d[i*HOLD_W +: HOLD_W] = '0;
                end
            end
        end
        if (clear) begin
            table_d    = table_q;
            keys_d     = '0;
            pressed_d  = '0;
            released_d = '0;
            hold_d     = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            table_q    <= DEFAULT_MAP;
            keys_q     <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            hold_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            table_q    <= table_d;
            keys_q     <= keys_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
        end
    end

    assign keys         = keys_q;
    assign key_pressed  = pressed_q;
    assign key_released = released_q;
    assign hold_cnt     = hold_q;
    assign proto_err    = err_q;

endmodule

// File: tb/tb_key_tracker.sv
// Table-driven bench for key_tracker: each record is one clock of stimulus plus the
// outputs expected one edge later; a hand loop covers hold-counter saturation.
module tb_key_tracker;

    localparam int NK = 14;
    localparam int HW = 8;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic [7:0]     byte_in = 8'h00;
    logic           byte_valid = 1'b0;
    logic           frame_tick = 1'b0;
    logic           clear = 1'b0;
    logic           cfg_we = 1'b0;
    logic [3:0]     cfg_idx = 4'd0;
    logic [8:0]     cfg_code = 9'h000;
    logic [NK-1:0]  keys, key_pressed, key_released;
    logic [NK*HW-1:0] hold_cnt;
    logic           proto_err;

    int checks = 0;
    int failures = 0;

    key_tracker #(.NUM_KEYS(NK), .HOLD_W(HW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_tick(frame_tick), .clear(clear), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_code(cfg_code), .keys(keys), .key_pressed(key_pressed),
        .key_released(key_released), .hold_cnt(hold_cnt), .proto_err(proto_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst_n;
        logic        bv;
        logic [7:0]  bt;
        logic        ft;
        logic        clr;
        logic        we;
        logic [3:0]  idx;
        logic [8:0]  code;
        logic [13:0] k;
        logic [13:0] p;
        logic [13:0] r;
        logic        e;
        int          hk;
        logic [7:0]  h;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_n, input logic bv, input logic [7:0] bt,
                                input logic ft, input logic clr, input logic we,
                                input logic [3:0] idx, input logic [8:0] code,
                                input logic [13:0] k, input logic [13:0] p,
                                input logic [13:0] r, input logic e,
                                input int hk, input logic [7:0] h);
        vec_t v;
        v.rst_n = rst_n; v.bv = bv; v.bt = bt; v.ft = ft; v.clr = clr; v.we = we;
        v.idx = idx; v.code = code; v.k = k; v.p = p; v.r = r; v.e = e;
        v.hk = hk; v.h = h;
        return v;
    endfunction

    function automatic vec_t by(input logic [7:0] bt, input logic ft, input logic [13:0] k,
                                input logic [13:0] p, input logic [13:0] r, input logic e,
                                input int hk, input logic [7:0] h);
        return mk(1'b1, 1'b1, bt, ft, 1'b0, 1'b0, 4'd0, 9'h000, k, p, r, e, hk, h);
    endfunction

    function automatic vec_t idl(input logic ft, input logic [13:0] k, input int hk,
                                 input logic [7:0] h);
        return mk(1'b1, 1'b0, 8'h00, ft, 1'b0, 1'b0, 4'd0, 9'h000, k, '0, '0, 1'b0, hk, h);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] hold_of(input int k);
        return hold_cnt[k*HW +: HW];
    endfunction

    task automatic apply(input vec_t v, input int tag);
        @(negedge Clk);
        Reset_n = v.rst_n; byte_valid = v.bv; byte_in = v.bt; frame_tick = v.ft;
        clear = v.clr; cfg_we = v.we; cfg_idx = v.idx; cfg_code = v.code;
        @(posedge Clk);
        #1;
        chk($sformatf("row%0d_keys", tag), 32'(keys), 32'(v.k));
        chk($sformatf("row%0d_pressed", tag), 32'(key_pressed), 32'(v.p));
        chk($sformatf("row%0d_released", tag), 32'(key_released), 32'(v.r));
        chk($sformatf("row%0d_proto_err", tag), 32'(proto_err), 32'(v.e));
        if (v.hk >= 0) chk($sformatf("row%0d_hold%0d", tag, v.hk), 32'(hold_of(v.hk)), 32'(v.h));
    endtask

    task automatic run_vecs(input int base);
        foreach (vecs[n]) apply(vecs[n], base + n);
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Make/break, extended codes, protocol errors, hold counting basics.
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000,
                          '0, '0, '0, 1'b0, 13, 8'd0));
        vecs.push_back(by(8'h1D, 1'b0, 14'h2000, 14'h2000, '0, 1'b0, -1, 8'd0));
        vecs.push_back(idl(1'b0, 14'h2000, -1, 8'd0));
        vecs.push_back(by(8'hF0, 1'b0, 14'h2000, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'h1D, 1'b0, '0, '0, 14'h2000, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'hE0, 1'b0, '0, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'h75, 1'b0, 14'h0040, 14'h0040, '0, 1'b0, 6, 8'd0));
        vecs.push_back(by(8'h75, 1'b0, 14'h0040, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'hE0, 1'b0, 14'h0040, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'hF0, 1'b0, 14'h0040, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'h75, 1'b0, '0, '0, 14'h0040, 1'b0, 6, 8'd0));
        vecs.push_back(by(8'hE0, 1'b0, '0, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'hE0, 1'b0, '0, '0, '0, 1'b1, -1, 8'd0));
        vecs.push_back(by(8'h6B, 1'b0, 14'h0010, 14'h0010, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'hF0, 1'b0, 14'h0010, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'hE0, 1'b0, 14'h0010, '0, '0, 1'b1, -1, 8'd0));
        vecs.push_back(by(8'h1D, 1'b0, 14'h2010, 14'h2000, '0, 1'b0, 13, 8'd0));
        vecs.push_back(idl(1'b1, 14'h2010, 13, 8'd1));
        vecs.push_back(by(8'h1D, 1'b1, 14'h2010, '0, '0, 1'b0, 13, 8'd2));
        vecs.push_back(by(8'hF0, 1'b0, 14'h2010, '0, '0, 1'b0, 13, 8'd2));
        vecs.push_back(by(8'h1D, 1'b1, 14'h0010, '0, 14'h2000, 1'b0, 13, 8'd0));
        vecs.push_back(by(8'hE0, 1'b0, 14'h0010, '0, '0, 1'b0, 4, 8'd3));
        vecs.push_back(by(8'hF0, 1'b0, 14'h0010, '0, '0, 1'b0, 4, 8'd3));
        vecs.push_back(by(8'h6B, 1'b1, '0, '0, 14'h0010, 1'b0, 4, 8'd0));
        vecs.push_back(by(8'h1C, 1'b1, 14'h1000, 14'h1000, '0, 1'b0, 12, 8'd0));
        run_vecs(0);

        // Saturation of hold_cnt[12] while 1C stays held.
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            byte_valid = 1'b0; frame_tick = 1'b1; clear = 1'b0; cfg_we = 1'b0;
            @(posedge Clk);
            #1;
            if (i == 253) chk("hold12_at_254", 32'(hold_of(12)), 32'd254);
        end
        chk("hold12_saturated", 32'(hold_of(12)), 32'd255);
        chk("keys_during_ticks", 32'(keys), 32'h1000);

        // Repeat make, table writes, reset mid-prefix, clear.
        vecs.push_back(by(8'h1C, 1'b0, 14'h1000, '0, '0, 1'b0, 12, 8'd255));
        vecs.push_back(by(8'hF0, 1'b0, 14'h1000, '0, '0, 1'b0, 12, 8'd255));
        vecs.push_back(by(8'h1C, 1'b0, '0, '0, 14'h1000, 1'b0, 12, 8'd0));
        vecs.push_back(by(8'h4A, 1'b0, 14'h0001, 14'h0001, '0, 1'b0, 0, 8'd0));
        vecs.push_back(idl(1'b1, 14'h0001, 0, 8'd1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 9'h01D,
                          '0, '0, '0, 1'b0, 0, 8'd0));
        vecs.push_back(by(8'h1D, 1'b0, 14'h2001, 14'h2001, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'hF0, 1'b0, 14'h2001, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'h1D, 1'b0, '0, '0, 14'h2001, 1'b0, -1, 8'd0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h1D, 1'b0, 1'b0, 1'b1, 4'd0, 9'h000,
                          14'h2000, 14'h2000, '0, 1'b0, 0, 8'd0));
        vecs.push_back(by(8'hF0, 1'b0, 14'h2000, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'h1D, 1'b0, '0, '0, 14'h2000, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'h4A, 1'b0, '0, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd14, 9'h04A,
                          '0, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'h4A, 1'b0, '0, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'hE0, 1'b0, '0, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000,
                          '0, '0, '0, 1'b0, 0, 8'd0));
        vecs.push_back(by(8'h74, 1'b0, '0, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'h4A, 1'b0, 14'h0001, 14'h0001, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'h1D, 1'b0, 14'h2001, 14'h2000, '0, 1'b0, -1, 8'd0));
        vecs.push_back(idl(1'b1, 14'h2001, 13, 8'd1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 9'h01D,
                          14'h2001, '0, '0, 1'b0, 13, 8'd1));
        vecs.push_back(mk(1'b1, 1'b1, 8'h1C, 1'b1, 1'b1, 1'b0, 4'd0, 9'h000,
                          '0, '0, '0, 1'b0, 13, 8'd0));
        vecs.push_back(by(8'hE0, 1'b0, '0, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 9'h000,
                          '0, '0, '0, 1'b0, -1, 8'd0));
        vecs.push_back(by(8'h75, 1'b0, '0, '0, '0, 1'b0, 6, 8'd0));
        vecs.push_back(by(8'h1D, 1'b0, 14'h2002, 14'h2002, '0, 1'b0, -1, 8'd0));
        vecs.push_back(idl(1'b1, 14'h2002, 1, 8'd1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 9'h000,
                          '0, '0, '0, 1'b0, 1, 8'd0));
        vecs.push_back(by(8'h4A, 1'b0, 14'h0001, 14'h0001, '0, 1'b0, -1, 8'd0));
        run_vecs(100);

        @(negedge Clk);
        byte_valid = 1'b0; frame_tick = 1'b0; clear = 1'b0; cfg_we = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
